// File: rtl/vga_pic_pkg.sv
// Shared constants for the VGA picture-window overlay: colour palette for
// RGB332 / RGB565, background mode encodings and a constant clog2.
package vga_pic_pkg;

   typedef enum logic [1:0] {
      BG_BARS  = 2'd0,
      BG_SOLID = 2'd1,
      BG_CHECK = 2'd2,
      BG_BLACK = 2'd3
   } bg_mode_e;

   localparam logic [7:0]  RED8    = 8'hE0;
   localparam logic [7:0]  GREEN8  = 8'h1C;
   localparam logic [7:0]  BLUE8   = 8'h03;
   localparam logic [7:0]  WHITE8  = 8'hFF;
   localparam logic [7:0]  BLACK8  = 8'h00;

   localparam logic [15:0] RED16   = 16'hF800;
   localparam logic [15:0] GREEN16 = 16'h07E0;
   localparam logic [15:0] BLUE16  = 16'h001F;
   localparam logic [15:0] WHITE16 = 16'hFFFF;
   localparam logic [15:0] BLACK16 = 16'h0000;

   // Smallest r with 2**r >= value; used for address widths.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Bar palette entry (0 red, 1 green, 2 blue, 3 white, 4+ black) in the
   // pixel format selected by dw, right-aligned in 16 bits.
   function automatic logic [15:0] bar_color(input logic [2:0] idx, input int dw);
      logic [15:0] c;
      case (idx)
         3'd0:    c = (dw == 16) ? RED16   : {8'h00, RED8};
         3'd1:    c = (dw == 16) ? GREEN16 : {8'h00, GREEN8};
         3'd2:    c = (dw == 16) ? BLUE16  : {8'h00, BLUE8};
         3'd3:    c = (dw == 16) ? WHITE16 : {8'h00, WHITE8};
         default: c = (dw == 16) ? BLACK16 : {8'h00, BLACK8};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/vga_pic_win_if.sv
// Picture write stream into the overlay RAM.
// Handshake: valid-only stream. wr_en is the valid; wr_sof and wr_data are
// meaningful only in a cycle with wr_en high. There is no ready: the sink
// accepts every pixel presented, one per vga_clk cycle.
interface vga_pic_win_if #(
   parameter int DW = 8
) ();
   logic          wr_en;
   logic          wr_sof;
   logic [DW-1:0] wr_data;

   modport master (output wr_en, output wr_sof, output wr_data);
   modport slave  (input  wr_en, input  wr_sof, input  wr_data);
endinterface

// File: rtl/dpram_sync.sv
// Simple dual-port RAM: one write port, one read port, single clock,
// registered read data (1-cycle latency). Contents are not reset.
module dpram_sync #(
   parameter int DW    = 8,
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [DEPTH];

   // Write port and synchronous read port.
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      q <= mem[ra];
   end

endmodule

// File: rtl/vga_pic_win.sv
// Picture-window overlay: ping-pong picture RAM written by an upstream
// stream, displayed at a frame-latched position with optional colour-key
// transparency over a selectable background. Banks swap only at the frame
// boundary (last active pixel) so a frame never mixes two pictures.
module vga_pic_win
   import vga_pic_pkg::*;
#(
   parameter int              H_VALID   = 640,
   parameter int              V_VALID   = 480,
   parameter int              PIC_W     = 98,
   parameter int              PIC_H     = 98,
   parameter int              DW        = 8,
   parameter int              BAR_NUM   = 10,
   parameter logic [DW-1:0]   KEY_COLOR = '0
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   vga_pic_win_if.slave      wr_if,
   input  logic              pic_en,
   input  logic              key_en,
   input  logic [1:0]        bg_mode,
   input  logic [DW-1:0]     bg_color,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   output logic [DW-1:0]     pix_data,
   output logic              frame_swap,
   output logic              disp_bank
);

   localparam int PIC_SIZE = PIC_W * PIC_H;
   localparam int AW       = clog2(PIC_SIZE);
   localparam int BAR_W    = H_VALID / BAR_NUM;

   localparam logic [DW-1:0] C_WHITE = DW'(bar_color(3'd3, DW));
   localparam logic [DW-1:0] C_BLACK = DW'(bar_color(3'd4, DW));

   logic [9:0]    sx, sy;
   logic          wr_bank, swap_pending;
   logic [AW-1:0] wr_addr, wr_addr_eff, row_base, rd_addr;
   logic          fb, wr_wrap, swap_now;
   logic          pix_act, row_in_win, hit;
   logic [10:0]   x_end, y_end;
   logic [9:0]    bar_idx;
   logic [DW-1:0] bg_now, bg_d, ram_q;
   logic          act_d, hit_d, key_d;
   logic [AW:0]   ram_wa, ram_ra;

   assign fb          = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
   assign wr_addr_eff = wr_if.wr_sof ? '0 : wr_addr;
   assign wr_wrap     = wr_if.wr_en && (wr_addr_eff == AW'(PIC_SIZE - 1));
   // A wrap in the boundary cycle itself swaps at this boundary.
   assign swap_now    = fb && (swap_pending || wr_wrap);

   // Write pointer: sof restarts at 0, last pixel wraps back to 0.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)       wr_addr <= '0;
      else if (wr_if.wr_en) wr_addr <= wr_wrap ? '0 : wr_addr_eff + AW'(1);
   end

   // Bank control, swap pulse and frame-latched window position.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         disp_bank    <= 1'b0;
         wr_bank      <= 1'b1;
         swap_pending <= 1'b0;
         frame_swap   <= 1'b0;
         sx           <= '0;
         sy           <= '0;
      end else begin
         frame_swap <= swap_now;
         if (swap_now) begin
            disp_bank    <= ~disp_bank;
            wr_bank      <= ~wr_bank;
            swap_pending <= 1'b0;
         end else if (wr_wrap) begin
            swap_pending <= 1'b1;
         end
         if (fb) begin
            sx <= pos_x;
            sy <= pos_y;
         end
      end
   end

   // Window hit test on the current pixel with 11-bit end sums so windows
   // hanging off the right/bottom edge clip instead of wrapping.
   always_comb begin
      pix_act    = (pix_x < 10'(H_VALID)) && (pix_y < 10'(V_VALID));
      x_end      = {1'b0, sx} + 11'(PIC_W);
      y_end      = {1'b0, sy} + 11'(PIC_H);
      row_in_win = (pix_y < 10'(V_VALID)) && (pix_y >= sy) && ({1'b0, pix_y} < y_end);
      hit        = pix_act && row_in_win && (pix_x >= sx) && ({1'b0, pix_x} < x_end);
      rd_addr    = row_base + AW'(pix_x - sx);
   end

   // Start-of-row address advances by one picture row at each window line end.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                                     row_base <= '0;
      else if (fb)                                        row_base <= '0;
      else if ((pix_x == 10'(H_VALID - 1)) && row_in_win) row_base <= row_base + AW'(PIC_W);
   end

   // Background colour for the current pixel.
   always_comb begin
      bar_idx = pix_x / 10'(BAR_W);
      bg_now  = C_BLACK;
      case (bg_mode_e'(bg_mode))
         BG_BARS: begin
            if (bar_idx < 10'(BAR_NUM)) bg_now = DW'(bar_color(3'(bar_idx % 10'd5), DW));
         end
         BG_SOLID: bg_now = bg_color;
         BG_CHECK: bg_now = (pix_x[5] ^ pix_y[5]) ? C_WHITE : C_BLACK;
         default:  bg_now = C_BLACK;
      endcase
   end

   // Pipeline stage aligned with the RAM read latency.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         act_d <= 1'b0;
         hit_d <= 1'b0;
         key_d <= 1'b0;
         bg_d  <= '0;
      end else begin
         act_d <= pix_act;
         hit_d <= hit && pic_en;
         key_d <= key_en;
         bg_d  <= bg_now;
      end
   end

   // Final select from registered sources: picture, else background, else 0.
   always_comb begin
      pix_data = '0;
      if (act_d) begin
         if (hit_d && !(key_d && (ram_q == KEY_COLOR))) pix_data = ram_q;
         else                                           pix_data = bg_d;
      end
   end

   // Bank 1 lives at offset PIC_SIZE so the RAM depth is exactly two pictures.
   assign ram_wa = wr_bank   ? ({1'b0, wr_addr_eff} + (AW+1)'(PIC_SIZE)) : {1'b0, wr_addr_eff};
   assign ram_ra = disp_bank ? ({1'b0, rd_addr}     + (AW+1)'(PIC_SIZE)) : {1'b0, rd_addr};

   dpram_sync #(
      .DW    (DW),
      .DEPTH (2 * PIC_SIZE),
      .AW    (AW + 1)
   ) u_ram (
      .clk (vga_clk),
      .we  (wr_if.wr_en),
      .wa  (ram_wa),
      .wd  (wr_if.wr_data),
      .ra  (ram_ra),
      .q   (ram_q)
   );

endmodule

// File: tb/tb_vga_pic_win.sv
// Bench for vga_pic_win: random pixel scans and picture writes checked
// against a frame/picture level model (pixel index = row*PIC_W + col).
module tb_vga_pic_win;

   localparam int PIC_W    = 98;
   localparam int PIC_H    = 98;
   localparam int DW       = 8;
   localparam int PIC_SIZE = PIC_W * PIC_H;
   localparam int EW       = 20 + 3 + DW;

   // clock / reset
   logic vga_clk   = 1'b0;
   logic sys_rst_n = 1'b1;
   initial forever #5 vga_clk = ~vga_clk;

   logic          pic_en = 1'b0, key_en = 1'b0;
   logic [1:0]    bg_mode = 2'd0;
   logic [DW-1:0] bg_color = '0;
   logic [9:0]    pos_x = '0, pos_y = '0, pix_x = 10'h3FF, pix_y = 10'h3FF;
   logic [DW-1:0] pix_data;
   logic          frame_swap, disp_bank;

   vga_pic_win_if #(.DW(DW)) wr_if ();

   vga_pic_win dut (
      .vga_clk    (vga_clk),
      .sys_rst_n  (sys_rst_n),
      .wr_if      (wr_if),
      .pic_en     (pic_en),
      .key_en     (key_en),
      .bg_mode    (bg_mode),
      .bg_color   (bg_color),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .pix_x      (pix_x),
      .pix_y      (pix_y),
      .pix_data   (pix_data),
      .frame_swap (frame_swap),
      .disp_bank  (disp_bank)
   );

   // configuration applied on the next driven cycle
   int cfg_pos_x = 0, cfg_pos_y = 0, cfg_pic_en = 0, cfg_key_en = 0;
   int cfg_bg_mode = 0, cfg_bg_color = 0;

   // reference model state
   int mem [2][PIC_SIZE];
   int m_disp, m_wrb, m_wra, m_pend, m_sx, m_sy;
   int bar_pal [5] = '{224, 28, 3, 255, 0};

   // scoreboard
   logic [EW-1:0] exp_q [$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_disp = 0; m_wrb = 1; m_wra = 0; m_pend = 0; m_sx = 0; m_sy = 0;
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < PIC_SIZE; a++) mem[b][a] = -1;
   endtask

   // Predict output for the inputs just driven, then advance the model.
   task automatic model_step();
      int x, y, bi, v, a, exp_pix;
      bit chk, wrap, swap;
      logic [EW-1:0] e;
      x = int'(pix_x); y = int'(pix_y);
      chk = 1'b1; wrap = 1'b0; swap = 1'b0; exp_pix = 0;
      if (x < 640 && y < 480) begin
         case (cfg_bg_mode)
            0: begin bi = x / 64; exp_pix = (bi >= 10) ? 0 : bar_pal[bi % 5]; end
            1: exp_pix = cfg_bg_color;
            2: exp_pix = (((x >> 5) ^ (y >> 5)) & 1) ? 255 : 0;
            default: exp_pix = 0;
         endcase
         if (cfg_pic_en != 0 && x >= m_sx && x < m_sx + PIC_W && y >= m_sy && y < m_sy + PIC_H) begin
            v = mem[m_disp][(y - m_sy) * PIC_W + (x - m_sx)];
            if (v < 0) chk = 1'b0;
            else if (!(cfg_key_en != 0 && v == 0)) exp_pix = v;
         end
      end
      if (wr_if.wr_en) begin
         a = wr_if.wr_sof ? 0 : m_wra;
         mem[m_wrb][a] = int'(wr_if.wr_data);
         if (a == PIC_SIZE - 1) begin m_wra = 0; wrap = 1'b1; end
         else m_wra = a + 1;
      end
      if (x == 639 && y == 479) begin
         m_sx = cfg_pos_x; m_sy = cfg_pos_y;
         if (m_pend != 0 || wrap) begin
            swap = 1'b1; m_disp = 1 - m_disp; m_wrb = 1 - m_wrb;
         end
      end
      m_pend = swap ? 0 : ((m_pend != 0 || wrap) ? 1 : 0);
      e = {pix_y, pix_x, chk, m_disp[0], swap, exp_pix[7:0]};
      exp_q.push_back(e);
   endtask

   // driver: one pixel-clock cycle
   task automatic cycle_w(input int x, input int y, input bit we, input bit sof, input int d);
      logic [EW-1:0] e;
      @(negedge vga_clk);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (e[10]) check_val($sformatf("pix_data(%0d,%0d)", e[20:11], e[30:21]), 32'(pix_data), 32'(e[7:0]));
         check_val("frame_swap", 32'(frame_swap), 32'(e[8]));
         check_val("disp_bank", 32'(disp_bank), 32'(e[9]));
      end
      pix_x = 10'(x); pix_y = 10'(y);
      wr_if.wr_en = we; wr_if.wr_sof = sof; wr_if.wr_data = 8'(d);
      pos_x = 10'(cfg_pos_x); pos_y = 10'(cfg_pos_y);
      pic_en = (cfg_pic_en != 0); key_en = (cfg_key_en != 0);
      bg_mode = 2'(cfg_bg_mode); bg_color = 8'(cfg_bg_color);
      model_step();
   endtask

   task automatic cycle(input int x, input int y);
      cycle_w(x, y, 1'b0, 1'b0, 0);
   endtask

   task automatic write_pic(input int n, input int kind);
      int d;
      for (int i = 0; i < n; i++) begin
         if (kind == 0) d = i % 256;
         else d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
         cycle_w(1023, 1023, 1'b1, (i == 0), d);
      end
   endtask

   task automatic async_reset();
      #2 sys_rst_n = 1'b0;
      #1;
      check_val("rst_pix_data", 32'(pix_data), 32'h0);
      check_val("rst_frame_swap", 32'(frame_swap), 32'h0);
      check_val("rst_disp_bank", 32'(disp_bank), 32'h0);
      exp_q.delete();
      m_reset();
      @(posedge vga_clk);
      #1 sys_rst_n = 1'b1;
   endtask

   // One frame scan; every window line gets its line-end cycle in order.
   task automatic run_frame(input int chg_line, input int nx, input int ny,
                            input bit fb_wr, input int fb_d, input int rst_line);
      int x, n;
      bit in_win;
      for (int y = 0; y < 480; y++) begin
         if (y == chg_line) begin cfg_pos_x = nx; cfg_pos_y = ny; end
         if (y == rst_line) async_reset();
         in_win = (y >= m_sy) && (y < m_sy + PIC_H);
         if (in_win && m_sx <= 638) cycle(m_sx, y);
         n = in_win ? 5 : 1;
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
               0: x = 1023;
               1: x = $urandom_range(0, 638);
               default: begin
                  x = m_sx + $urandom_range(0, PIC_W - 1);
                  if (x > 638) x = 638;
               end
            endcase
            cycle(x, (x == 1023 && k == 0) ? 1023 : y);
         end
         if (y == 479 && fb_wr) cycle_w(639, y, 1'b1, 1'b0, fb_d);
         else cycle(639, y);
      end
      cycle(1023, 1023);
      cycle(1023, 1023);
   endtask

   initial begin
      wr_if.wr_en = 1'b0; wr_if.wr_sof = 1'b0; wr_if.wr_data = '0;
      m_reset();
      #2 sys_rst_n = 1'b0;
      #1;
      check_val("reset_pix_data", 32'(pix_data), 32'h0);
      check_val("reset_frame_swap", 32'(frame_swap), 32'h0);
      check_val("reset_disp_bank", 32'(disp_bank), 32'h0);
      repeat (3) @(posedge vga_clk);
      @(negedge vga_clk);
      sys_rst_n = 1'b1;

      // colour bars, no picture
      cycle(0, 0); cycle(63, 0); cycle(64, 0); cycle(127, 0);
      cycle(128, 0); cycle(191, 0); cycle(1023, 0); cycle(1023, 1023);
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      // ramp picture, swap at the next boundary, then display it
      cfg_pos_x = 271; cfg_pos_y = 191; cfg_pic_en = 1;
      write_pic(PIC_SIZE, 0);
      run_frame(-1, 0, 0, 1'b0, 0, -1);
      check_val("bank_after_ramp", 32'(disp_bank), 32'h1);
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      // right/bottom clipping, then a mid-frame position change
      cfg_pos_x = 600; cfg_pos_y = 400;
      run_frame(-1, 0, 0, 1'b0, 0, -1);
      run_frame(-1, 0, 0, 1'b0, 0, -1);
      run_frame(200, 100, 20, 1'b0, 0, -1);
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      // colour key over a solid background
      cfg_key_en = 1; cfg_bg_mode = 1; cfg_bg_color = 8'h55;
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      // checkerboard and black backgrounds
      cfg_key_en = 0; cfg_bg_mode = 2;
      run_frame(-1, 0, 0, 1'b0, 0, -1);
      cfg_bg_mode = 3;
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      // partial picture: no swap; full picture: swap
      cfg_bg_mode = 0; cfg_key_en = 1;
      write_pic(PIC_SIZE / 2, 1);
      run_frame(-1, 0, 0, 1'b0, 0, -1);
      write_pic(PIC_SIZE, 1);
      run_frame(-1, 0, 0, 1'b0, 0, -1);
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      // last picture pixel lands in the boundary cycle itself
      write_pic(PIC_SIZE - 1, 1);
      run_frame(-1, 0, 0, 1'b1, 8'hA7, -1);
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      // asynchronous reset mid-frame, then recovery
      run_frame(-1, 0, 0, 1'b0, 0, 300);
      run_frame(-1, 0, 0, 1'b0, 0, -1);

      cycle(1023, 1023);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vga_pic_win.md
Name: vga_pic_win

Overview:
- Parametrised picture-window overlay for the VGA output path, fed by vga_ctrl pix_x/pix_y; drives pix_data to the VGA output.
- Stores a PIC_W x PIC_H image in an internal double-buffered (ping-pong) RAM, written by an upstream pixel stream already in the vga_clk domain.
- Displays the image at a runtime position, with colour-key transparency, over a selectable background (colour bars, solid, checkerboard, black).
- Banks swap only at frame boundaries, so there is no tearing.

Parameters:
- H_VALID, 640, active pixels per line.
- V_VALID, 480, active lines per frame.
- PIC_W, 98, picture width in pixels.
- PIC_H, 98, picture height in lines.
- DW, 8, pixel width: 8 = RGB332, 16 = RGB565.
- BAR_NUM, 10, number of background colour bars; bar width is H_VALID/BAR_NUM.
- KEY_COLOR, 0, transparent colour value.
- Derived localparams: PIC_SIZE = PIC_W*PIC_H; AW = clog2(PIC_SIZE).

Ports:
- vga_clk, in, 1, pixel clock; all logic runs on it.
- sys_rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, write strobe for one picture pixel.
- wr_sof, in, 1, qualifies wr_en: the pixel is address 0 of a new picture.
- wr_data, in, DW, picture pixel.
- pic_en, in, 1, enables the picture overlay.
- key_en, in, 1, enables colour-key transparency.
- bg_mode, in, 2, background select: 0 bars, 1 solid, 2 checker, 3 black.
- bg_color, in, DW, solid background colour.
- pos_x, in, 10, picture left column.
- pos_y, in, 10, picture top line.
- pix_x, in, 10, current pixel column; 10'h3FF when outside the active region.
- pix_y, in, 10, current pixel line; 10'h3FF when outside the active region.
- pix_data, out, DW, output pixel.
- frame_swap, out, 1, one-cycle pulse when the display bank swaps.
- disp_bank, out, 1, bank currently being displayed.

Behaviour:
- Reset values:
  - pix_data = 0, frame_swap = 0, disp_bank = 0.
  - Write bank = 1, wr_addr = 0, swap_pending = 0, row_base = 0.
  - Shadow position registers = 0.
- Latency:
  - pix_data is registered and belongs to the pix_x/pix_y presented one cycle earlier.
  - The RAM read is synchronous (1 cycle), so the picture and background paths are equally delayed.
- Frame boundary (FB): the cycle with pix_x == H_VALID-1 and pix_y == V_VALID-1. On FB:
  - pos_x and pos_y are latched into shadow registers; mid-frame position changes never take effect.
  - row_base clears.
  - If swap_pending, disp_bank toggles, the write bank toggles, swap_pending clears and frame_swap pulses on the next cycle.
- Write side:
  - wr_en writes wr_data to {wr_bank, wr_addr}.
  - wr_en with wr_sof writes address 0, then wr_addr = 1.
  - wr_en at wr_addr == PIC_SIZE-1 wraps wr_addr to 0 and sets swap_pending.
  - wr_en without wr_sof otherwise increments wr_addr.
  - wr_en at PIC_SIZE-1 in the FB cycle: the swap happens at this FB (the pending set and the swap coincide).
  - Writes never touch disp_bank.
- Window hit (current pixel):
  - Condition: pix_x in [sx, sx+PIC_W) and pix_y in [sy, sy+PIC_H), using shadow values sx/sy. Compare with 11-bit sums.
  - Any pix value at or above H_VALID/V_VALID (including 3FF) is never a hit.
  - A window that extends past the right or bottom edge is clipped; the visible part shows the correct pixels.
- Read address:
  - rd_addr = row_base + (pix_x - sx), read from bank disp_bank.
  - At pix_x == H_VALID-1 on a line inside [sy, sy+PIC_H), row_base += PIC_W.
  - No multiplier is used.
- Output select, registered, evaluated in this order:
  1. Delayed hit and pic_en and NOT (key_en and q == KEY_COLOR): RAM q.
  2. Otherwise the background for the delayed pixel.
  3. Any non-active pixel: 0.
- Background:
  - Mode 0: bar index = pix_x/(H_VALID/BAR_NUM); palette cycles RED, GREEN, BLUE, WHITE, BLACK by index mod 5. Pixels at or beyond BAR_NUM*barwidth are BLACK.
  - Mode 1: bg_color.
  - Mode 2: WHITE when pix_x[5] xor pix_y[5] is 1, else BLACK (32x32 checker).
  - Mode 3: BLACK.
- Reset mid-frame: everything returns to reset values asynchronously; the display restarts cleanly at the next FB; the RAM contents are undefined.

Decomposition:
- Package vga_pic_pkg holds:
  - Colour constants for DW = 8 and DW = 16: RED, GREEN, BLUE, WHITE, BLACK.
  - bg_mode encodings.
  - A clog2 function.
- Sub-module dpram_sync: a simple dual-port RAM with depth 2*PIC_SIZE, width DW, single clock, 1-cycle read, inferred.

Test Plan:
- Reset, then bg_mode = 0, pic_en = 0, full frame -> pix_x 0..63 gives 8'hE0, 64..127 gives 8'h1C, 128..191 gives 8'h03; pix_x = 3FF gives 0; frame_swap stays 0.
- Write a 98x98 ramp (value = addr[7:0]) with wr_sof on the first pixel, pos = (271, 191), pic_en = 1 -> swap pulse at the next FB, disp_bank = 1; pixel (271,191) = 8'h00, (272,191) = 8'h01, (271,192) = 98 mod 256.
- pos_x = 600 -> columns 600..639 show addresses 0..39 of each row; the next row starts at row_base + 98; no wrap into column 0.
- Change pos_y mid-frame -> the current frame is unchanged; the new position applies after FB.
- key_en = 1, KEY_COLOR = 0, bg_mode = 1, bg_color = 8'h55 -> window pixels holding 0 output 8'h55; others output RAM data.
- Write half a picture, then a full picture -> no swap until wr_addr wraps; disp_bank never changes while the write is partial; async reset mid-frame makes pix_data 0 immediately.
